// File: rtl/thread_register_file.sv
// Per-thread register file: GPRs, read-only block_id/block_dim/thread_id registers and a load scoreboard.
// Optional build macro WRITE_BYPASS_EN forwards same-cycle writes to the read ports and hazard.
module thread_register_file #(
  parameter int DATA_WIDTH        = 8,
  parameter int NUM_REGS          = 16,
  parameter int ADDR_WIDTH        = $clog2(NUM_REGS),
  parameter int THREADS_PER_BLOCK = 4,
  parameter int THREAD_ID         = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [2:0]            core_state,
  input  logic                  reg_write_enable,
  input  logic [1:0]            reg_input_mux,
  input  logic [ADDR_WIDTH-1:0] rs_address,
  input  logic [ADDR_WIDTH-1:0] rt_address,
  input  logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic [DATA_WIDTH-1:0] lsu_out,
  input  logic [DATA_WIDTH-1:0] immediate,
  input  logic [DATA_WIDTH-1:0] block_id,
  input  logic                  lsu_issue,
  input  logic [ADDR_WIDTH-1:0] lsu_issue_rd,
  input  logic                  lsu_ret_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_ret_rd,
  input  logic [DATA_WIDTH-1:0] lsu_ret_data,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  hazard,
  output logic                  sb_error
);

  localparam logic [2:0]            UPDATE        = 3'b110;
  localparam logic [ADDR_WIDTH-1:0] LAST_GPR      = ADDR_WIDTH'(NUM_REGS - 4);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_ID_IDX  = ADDR_WIDTH'(NUM_REGS - 3);
  localparam logic [ADDR_WIDTH-1:0] BLOCK_DIM_IDX = ADDR_WIDTH'(NUM_REGS - 2);
  localparam logic [ADDR_WIDTH-1:0] THREAD_IDX    = ADDR_WIDTH'(NUM_REGS - 1);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;
  logic [NUM_REGS-1:0]   live_pending;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_fire;
  logic                  ret_gpr;
  logic                  issue_gpr;
  logic                  ret_fire;
  logic                  issue_fire;
  logic                  same_slot;
  logic                  sb_event;

  always_comb begin
    wr_data = '0;
    unique case (reg_input_mux)
      2'b00:   wr_data = alu_out;
      2'b01:   wr_data = lsu_out;
      2'b10:   wr_data = immediate;
      default: wr_data = '0;
    endcase
  end

  assign wr_fire    = enable && reg_write_enable && (core_state == UPDATE) && (rd_address <= LAST_GPR);
  assign ret_gpr    = lsu_ret_rd <= LAST_GPR;
  assign issue_gpr  = lsu_issue_rd <= LAST_GPR;
  assign ret_fire   = enable && lsu_ret_valid && ret_gpr;
  assign issue_fire = enable && lsu_issue && issue_gpr;
  // A return and a re-issue to the same register in one cycle is a legal chained load.
  assign same_slot  = lsu_issue && lsu_ret_valid && (lsu_issue_rd == lsu_ret_rd);

  always_comb begin
    sb_event = 1'b0;
    if (lsu_issue && !issue_gpr) sb_event = 1'b1;
    if (lsu_issue && issue_gpr && pending[lsu_issue_rd] && !same_slot) sb_event = 1'b1;
    if (lsu_ret_valid && !ret_gpr) sb_event = 1'b1;
    if (lsu_ret_valid && ret_gpr && !pending[lsu_ret_rd] && !same_slot) sb_event = 1'b1;
  end

  always_comb begin
    pending_next = pending;
    if (ret_fire)   pending_next[lsu_ret_rd]   = 1'b0;
    if (issue_fire) pending_next[lsu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS - 3; i++) regs[i] <= '0;
      regs[BLOCK_ID_IDX]  <= '0;
      regs[BLOCK_DIM_IDX] <= DATA_WIDTH'(THREADS_PER_BLOCK);
      regs[THREAD_IDX]    <= DATA_WIDTH'(THREAD_ID);
      pending             <= '0;
      sb_error            <= 1'b0;
    end else if (enable) begin
      regs[BLOCK_ID_IDX] <= block_id;
      if (ret_fire) regs[lsu_ret_rd] <= lsu_ret_data;
      // Pipeline writeback is issued later in program order, so it overrides a colliding return.
      if (wr_fire)  regs[rd_address] <= wr_data;
      pending <= pending_next;
      if (sb_event) sb_error <= 1'b1;
    end
  end

`ifdef WRITE_BYPASS_EN
  always_comb begin
    rs_data = regs[rs_address];
    if (ret_fire && (lsu_ret_rd == rs_address)) rs_data = lsu_ret_data;
    if (wr_fire && (rd_address == rs_address))  rs_data = wr_data;
  end

  always_comb begin
    rt_data = regs[rt_address];
    if (ret_fire && (lsu_ret_rd == rt_address)) rt_data = lsu_ret_data;
    if (wr_fire && (rd_address == rt_address))  rt_data = wr_data;
  end

  always_comb begin
    live_pending = pending;
    if (ret_fire) live_pending[lsu_ret_rd] = 1'b0;
  end
`else
  assign rs_data      = regs[rs_address];
  assign rt_data      = regs[rt_address];
  assign live_pending = pending;
`endif

  assign hazard = live_pending[rs_address] || live_pending[rt_address] ||
                  (reg_write_enable && live_pending[rd_address]);

endmodule

// File: tb/tb_thread_register_file.sv
// Bench for thread_register_file: directed scenarios followed by randomized traffic against an array model.
module tb_thread_register_file;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] core_state;
  logic       reg_write_enable;
  logic [1:0] reg_input_mux;
  logic [3:0] rs_address, rt_address, rd_address;
  logic [7:0] alu_out, lsu_out, immediate, block_id;
  logic       lsu_issue;
  logic [3:0] lsu_issue_rd;
  logic       lsu_ret_valid;
  logic [3:0] lsu_ret_rd;
  logic [7:0] lsu_ret_data;
  logic [7:0] rs_data, rt_data;
  logic       hazard, sb_error;

  int tests = 0;
  int fails = 0;

  logic [7:0] m_regs [16];
  logic       m_pend [16];
  logic       m_err;

  thread_register_file #(
    .DATA_WIDTH(8), .NUM_REGS(16), .ADDR_WIDTH(4), .THREADS_PER_BLOCK(4), .THREAD_ID(3)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .core_state(core_state),
    .reg_write_enable(reg_write_enable), .reg_input_mux(reg_input_mux),
    .rs_address(rs_address), .rt_address(rt_address), .rd_address(rd_address),
    .alu_out(alu_out), .lsu_out(lsu_out), .immediate(immediate), .block_id(block_id),
    .lsu_issue(lsu_issue), .lsu_issue_rd(lsu_issue_rd), .lsu_ret_valid(lsu_ret_valid),
    .lsu_ret_rd(lsu_ret_rd), .lsu_ret_data(lsu_ret_data),
    .rs_data(rs_data), .rt_data(rt_data), .hazard(hazard), .sb_error(sb_error)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_regs[i] = 8'h00;
      m_pend[i] = 1'b0;
    end
    m_regs[14] = 8'd4;
    m_regs[15] = 8'd3;
    m_err = 1'b0;
  endtask

  function automatic logic [7:0] wr_value();
    case (reg_input_mux)
      2'd0:    return alu_out;
      2'd1:    return lsu_out;
      2'd2:    return immediate;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic wr_now();
    return enable && reg_write_enable && core_state == 3'b110 && rd_address <= 4'd12;
  endfunction

  function automatic logic ret_now();
    return enable && lsu_ret_valid && lsu_ret_rd <= 4'd12;
  endfunction

  function automatic logic [7:0] exp_read(input logic [3:0] a);
`ifdef WRITE_BYPASS_EN
    if (wr_now() && rd_address == a) return wr_value();
    if (ret_now() && lsu_ret_rd == a) return lsu_ret_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_hazard();
    logic p [16];
    for (int i = 0; i < 16; i++) p[i] = m_pend[i];
`ifdef WRITE_BYPASS_EN
    if (ret_now()) p[lsu_ret_rd] = 1'b0;
`endif
    return p[rs_address] || p[rt_address] || (reg_write_enable && p[rd_address]);
  endfunction

  task automatic model_update();
    logic iss_ok, same;
    if (reset) begin
      model_reset();
      return;
    end
    if (!enable) return;
    iss_ok = lsu_issue && lsu_issue_rd <= 4'd12;
    same   = lsu_issue && lsu_ret_valid && lsu_issue_rd == lsu_ret_rd;
    if (lsu_issue && !iss_ok) m_err = 1'b1;
    if (iss_ok && m_pend[lsu_issue_rd] && !same) m_err = 1'b1;
    if (lsu_ret_valid && lsu_ret_rd > 4'd12) m_err = 1'b1;
    if (ret_now() && !m_pend[lsu_ret_rd] && !same) m_err = 1'b1;
    m_regs[13] = block_id;
    if (ret_now()) begin
      m_regs[lsu_ret_rd] = lsu_ret_data;
      m_pend[lsu_ret_rd] = 1'b0;
    end
    if (wr_now()) m_regs[rd_address] = wr_value();
    if (iss_ok) m_pend[lsu_issue_rd] = 1'b1;
  endtask

  task automatic idle();
    reset = 1'b0; enable = 1'b1; core_state = 3'b000; reg_write_enable = 1'b0;
    reg_input_mux = 2'd0; rd_address = 4'd0; alu_out = 8'h00; lsu_out = 8'h00;
    immediate = 8'h00; lsu_issue = 1'b0; lsu_issue_rd = 4'd0; lsu_ret_valid = 1'b0;
    lsu_ret_rd = 4'd0; lsu_ret_data = 8'h00;
  endtask

  task automatic step();
    #1;
    check("rs_data", {24'd0, rs_data}, {24'd0, exp_read(rs_address)});
    check("rt_data", {24'd0, rt_data}, {24'd0, exp_read(rt_address)});
    check("hazard", {31'd0, hazard}, {31'd0, exp_hazard()});
    check("sb_error", {31'd0, sb_error}, {31'd0, m_err});
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic sweep();
    idle();
    for (int a = 0; a < 16; a += 2) begin
      rs_address = 4'(a);
      rt_address = 4'(a + 1);
      block_id   = 8'($urandom_range(0, 255));
      step();
    end
  endtask

  initial begin
    idle();
    reset = 1'b1; rs_address = 4'd0; rt_address = 4'd0; block_id = 8'h00;
    @(posedge clock);
    @(posedge clock);
    model_reset();
    @(negedge clock);

    // Reset contents
    idle();
    rs_address = 4'd14; rt_address = 4'd15;
    #1;
    check("t1_block_dim", {24'd0, rs_data}, 32'd4);
    check("t1_thread_id", {24'd0, rt_data}, 32'd3);
    check("t1_hazard", {31'd0, hazard}, 32'd0);
    check("t1_sb_error", {31'd0, sb_error}, 32'd0);
    sweep();

    // Pipeline writes: GPR lands, read-only target dropped
    idle();
    core_state = 3'b110; reg_write_enable = 1'b1; rd_address = 4'd5; alu_out = 8'h2A;
    step();
    idle(); rs_address = 4'd5;
    #1 check("t2_reg5", {24'd0, rs_data}, 32'h2A);
    step();
    core_state = 3'b110; reg_write_enable = 1'b1; rd_address = 4'd14; alu_out = 8'h55;
    step();
    idle(); rs_address = 4'd14;
    #1 check("t2_reg14", {24'd0, rs_data}, 32'd4);
    step();

    // Disabled thread keeps state
    enable = 1'b0; core_state = 3'b110; reg_write_enable = 1'b1; rd_address = 4'd8;
    alu_out = 8'hEE; block_id = 8'h42;
    step();
    idle(); rs_address = 4'd8; rt_address = 4'd13;
    #1 check("en_low_reg8", {24'd0, rs_data}, 32'h00);
    step();

    // Load issue, hazard, delayed return
    idle(); lsu_issue = 1'b1; lsu_issue_rd = 4'd3; rs_address = 4'd3;
    step();
    idle(); rs_address = 4'd3;
    #1 check("t3_hazard_set", {31'd0, hazard}, 32'd1);
    for (int i = 0; i < 3; i++) step();
    lsu_ret_valid = 1'b1; lsu_ret_rd = 4'd3; lsu_ret_data = 8'h77;
    step();
    idle(); rs_address = 4'd3;
    #1;
    check("t3_reg3", {24'd0, rs_data}, 32'h77);
    check("t3_hazard_clr", {31'd0, hazard}, 32'd0);
    check("t3_sb_error", {31'd0, sb_error}, 32'd0);
    step();

    // Pipeline write beats same-cycle return
    idle(); lsu_issue = 1'b1; lsu_issue_rd = 4'd2;
    step();
    idle(); core_state = 3'b110; reg_write_enable = 1'b1; rd_address = 4'd2; alu_out = 8'h11;
    lsu_ret_valid = 1'b1; lsu_ret_rd = 4'd2; lsu_ret_data = 8'h99;
    step();
    idle(); rs_address = 4'd2;
    #1;
    check("t4_reg2", {24'd0, rs_data}, 32'h11);
    check("t4_pending2", {31'd0, hazard}, 32'd0);
    step();

    // Stray return sets sticky error; reset clears a load in flight
    idle(); lsu_ret_valid = 1'b1; lsu_ret_rd = 4'd4; lsu_ret_data = 8'h3C;
    step();
    idle(); rs_address = 4'd4;
    #1;
    check("t5_reg4", {24'd0, rs_data}, 32'h3C);
    check("t5_sb_error", {31'd0, sb_error}, 32'd1);
    step();
    lsu_issue = 1'b1; lsu_issue_rd = 4'd7;
    step();
    idle(); rs_address = 4'd7; reset = 1'b1;
    step();
    idle(); rs_address = 4'd7;
    #1;
    check("t5_pend_reset", {31'd0, hazard}, 32'd0);
    check("t5_err_reset", {31'd0, sb_error}, 32'd0);
    lsu_ret_valid = 1'b1; lsu_ret_rd = 4'd7; lsu_ret_data = 8'hA5;
    step();
    idle(); rs_address = 4'd7;
    #1;
    check("t5_late_data", {24'd0, rs_data}, 32'hA5);
    check("t5_late_err", {31'd0, sb_error}, 32'd1);
    step();

    // Read-only issue flags error; return visibility in the returning cycle
    idle(); reset = 1'b1;
    step();
    idle(); lsu_issue = 1'b1; lsu_issue_rd = 4'd15;
    step();
    idle();
    #1 check("ro_issue_err", {31'd0, sb_error}, 32'd1);
    reset = 1'b1;
    step();
    idle(); lsu_issue = 1'b1; lsu_issue_rd = 4'd6;
    step();
    idle(); rs_address = 4'd6; lsu_ret_valid = 1'b1; lsu_ret_rd = 4'd6; lsu_ret_data = 8'h5C;
    #1;
`ifdef WRITE_BYPASS_EN
    check("t6_rs_bypass", {24'd0, rs_data}, 32'h5C);
    check("t6_hazard_bypass", {31'd0, hazard}, 32'd0);
`else
    check("t6_rs_old", {24'd0, rs_data}, 32'h00);
    check("t6_hazard_old", {31'd0, hazard}, 32'd1);
`endif
    step();
    idle(); rs_address = 4'd6;
    #1 check("t6_reg6", {24'd0, rs_data}, 32'h5C);
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset            = ($urandom_range(0, 49) == 0);
      enable           = ($urandom_range(0, 9) != 0);
      core_state       = ($urandom_range(0, 1) == 1) ? 3'b110 : 3'($urandom_range(0, 7));
      reg_write_enable = 1'($urandom_range(0, 1));
      reg_input_mux    = 2'($urandom_range(0, 3));
      rs_address       = 4'($urandom_range(0, 15));
      rt_address       = 4'($urandom_range(0, 15));
      rd_address       = 4'($urandom_range(0, 15));
      alu_out          = 8'($urandom_range(0, 255));
      lsu_out          = 8'($urandom_range(0, 255));
      immediate        = 8'($urandom_range(0, 255));
      block_id         = 8'($urandom_range(0, 255));
      lsu_issue        = ($urandom_range(0, 3) == 0);
      lsu_issue_rd     = 4'($urandom_range(0, 13));
      lsu_ret_valid    = ($urandom_range(0, 3) == 0);
      lsu_ret_rd       = 4'($urandom_range(0, 13));
      lsu_ret_data     = 8'($urandom_range(0, 255));
      step();
    end
    sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
